// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared definitions for the pipelined RV32I core. This package
//               holds the datapath widths, the 4-bit ALU opcode encodings, and
//               the packed ID/EX pipeline register layout. It also provides a
//               helper that recognises shift opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // ALU opcode encodings; bit 3 selects the "alternate" variant (sub/sra)
    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SUB  = 4'b1000;
    localparam logic [3:0] c_ALU_SLL  = 4'b0001;
    localparam logic [3:0] c_ALU_SLT  = 4'b0010;
    localparam logic [3:0] c_ALU_SLTU = 4'b0011;
    localparam logic [3:0] c_ALU_XOR  = 4'b0100;
    localparam logic [3:0] c_ALU_SRL  = 4'b0101;
    localparam logic [3:0] c_ALU_SRA  = 4'b1101;
    localparam logic [3:0] c_ALU_OR   = 4'b0110;
    localparam logic [3:0] c_ALU_AND  = 4'b0111;
    localparam logic [3:0] c_ALU_EQ   = 4'b1001;
    localparam logic [3:0] c_ALU_LUI  = 4'b1111;

    // Registered ID/EX fields
    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [3:0]            alu_op;
        logic                  use_imm;
        logic                  use_pc;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
    } idex_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == c_ALU_SLL) || (op == c_ALU_SRL) || (op == c_ALU_SRA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : fwd_mux
// Description : Two-source priority forward select for a single source
//               operand. The EX/MEM result takes precedence over the MEM/WB
//               result, because EX/MEM holds the younger producer. When
//               neither stage matches, the register-file value passes through.
//               Register x0 is never forwarded.
// Ports       : i_rs                   source register index
//               i_rf_data              register-file value captured in ID
//               i_exmem_reg_write/rd/result   EX/MEM producer
//               i_memwb_reg_write/rd/result   MEM/WB producer
//               o_data                 resolved operand
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic [XLEN-1:0]       i_rf_data,
    input  logic                  i_exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] i_exmem_rd,
    input  logic [XLEN-1:0]       i_exmem_result,
    input  logic                  i_memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] i_memwb_rd,
    input  logic [XLEN-1:0]       i_memwb_result,
    output logic [XLEN-1:0]       o_data
);

    logic w_hit_exmem;
    logic w_hit_memwb;

    assign w_hit_exmem = i_exmem_reg_write && (i_exmem_rd != '0) && (i_exmem_rd == i_rs);
    assign w_hit_memwb = i_memwb_reg_write && (i_memwb_rd != '0) && (i_memwb_rd == i_rs);

    always_comb begin
        o_data = i_rf_data;
        if (w_hit_exmem) begin
            o_data = i_exmem_result;
        end else if (w_hit_memwb) begin
            o_data = i_memwb_result;
        end
    end

endmodule
`default_nettype wire

// File: rtl/idex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : idex_operand_stage
// Description : ID/EX pipeline register with EX-side operand forwarding and
//               load-use hazard detection. Its outputs drive the ALU opcode,
//               both ALU operands, the forwarded store data, and the gated
//               control bits for EX/MEM.
// Ports       : clk, rst_n (async, active-low)
//               id_*             decoded instruction fields from ID
//               exmem_*/memwb_*  forwarding sources
//               hold             freeze the register
//               flush            kill the register contents
//               load_use_stall   ID/IF must hold this cycle
//               ex_valid, alu_op, alu_op1, alu_op2, ex_store_data, ex_rd,
//               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch
// Revision    : 1.0 - initial release
// ============================================================================
module idex_operand_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [3:0]            id_alu_op,
    input  logic                  id_use_imm,
    input  logic                  id_use_pc,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_branch,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]       exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]       memwb_result,
    input  logic                  hold,
    input  logic                  flush,
    output logic                  load_use_stall,
    output logic                  ex_valid,
    output logic [3:0]            alu_op,
    output logic [XLEN-1:0]       alu_op1,
    output logic [XLEN-1:0]       alu_op2,
    output logic [XLEN-1:0]       ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_branch
);

    import riscv_pkg::*;

    idex_t           r_idex;
    idex_t           w_id_fields;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;
    logic [XLEN-1:0] w_imm_eff;

    always_comb begin
        w_id_fields           = '0;
        w_id_fields.valid     = id_valid;
        w_id_fields.pc        = id_pc;
        w_id_fields.rs1_data  = id_rs1_data;
        w_id_fields.rs2_data  = id_rs2_data;
        w_id_fields.imm       = id_imm;
        w_id_fields.rs1       = id_rs1;
        w_id_fields.rs2       = id_rs2;
        w_id_fields.rd        = id_rd;
        w_id_fields.alu_op    = id_alu_op;
        w_id_fields.use_imm   = id_use_imm;
        w_id_fields.use_pc    = id_use_pc;
        w_id_fields.reg_write = id_reg_write;
        w_id_fields.mem_read  = id_mem_read;
        w_id_fields.mem_write = id_mem_write;
        w_id_fields.branch    = id_branch;
    end

    // A load that is about to be flushed cannot create a hazard.
    assign load_use_stall = !flush && id_valid && r_idex.valid && r_idex.mem_read
                            && (r_idex.rd != '0)
                            && ((r_idex.rd == id_rs1) || (r_idex.rd == id_rs2));

    // Flush and bubble clear only valid and control; data fields are left
    // alone because the gated controls make them harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idex <= '0;
        end else if (flush || (!hold && load_use_stall)) begin
            r_idex.valid     <= 1'b0;
            r_idex.reg_write <= 1'b0;
            r_idex.mem_read  <= 1'b0;
            r_idex.mem_write <= 1'b0;
            r_idex.branch    <= 1'b0;
        end else if (!hold) begin
            r_idex <= w_id_fields;
        end
    end

    fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
        .i_rs              (r_idex.rs1),
        .i_rf_data         (r_idex.rs1_data),
        .i_exmem_reg_write (exmem_reg_write),
        .i_exmem_rd        (exmem_rd),
        .i_exmem_result    (exmem_result),
        .i_memwb_reg_write (memwb_reg_write),
        .i_memwb_rd        (memwb_rd),
        .i_memwb_result    (memwb_result),
        .o_data            (w_fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
        .i_rs              (r_idex.rs2),
        .i_rf_data         (r_idex.rs2_data),
        .i_exmem_reg_write (exmem_reg_write),
        .i_exmem_rd        (exmem_rd),
        .i_exmem_result    (exmem_result),
        .i_memwb_reg_write (memwb_reg_write),
        .i_memwb_rd        (memwb_rd),
        .i_memwb_result    (memwb_result),
        .o_data            (w_fwd_rs2)
    );

    // Shift immediates carry funct7 in imm[11:5] (srai); only the shamt is kept.
    assign w_imm_eff = is_shift_op(r_idex.alu_op) ? {{(XLEN-5){1'b0}}, r_idex.imm[4:0]}
                                                  : r_idex.imm;

    assign ex_valid      = r_idex.valid;
    assign alu_op        = r_idex.alu_op;
    assign alu_op1       = r_idex.use_pc  ? r_idex.pc : w_fwd_rs1;
    assign alu_op2       = r_idex.use_imm ? w_imm_eff : w_fwd_rs2;
    assign ex_store_data = w_fwd_rs2;
    assign ex_rd         = r_idex.rd;
    assign ex_reg_write  = r_idex.valid & r_idex.reg_write;
    assign ex_mem_read   = r_idex.valid & r_idex.mem_read;
    assign ex_mem_write  = r_idex.valid & r_idex.mem_write;
    assign ex_branch     = r_idex.valid & r_idex.branch;

endmodule
`default_nettype wire
